// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// The MEM_ARB_RR_EN build switch is consumed by mem_arb_sel and mem_arbiter.
package mem_arb_pkg;

    localparam int unsigned ISA_WIDTH      = 32;
    localparam int unsigned MEM_MASK_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_IF) ? OWN_LSU : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between the fetch and LSU requesters.
// MEM_ARB_RR_EN: ties alternate; otherwise the LSU always wins a tie.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic if_valid_i,
    input  logic lsu_valid_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant_i,
`endif
    output logic grant_o,
    output logic winner_o
);

    always_comb begin
        grant_o  = if_valid_i | lsu_valid_i;
        winner_o = OWN_IF;
        if (if_valid_i && lsu_valid_i) begin
`ifdef MEM_ARB_RR_EN
            // Whoever did not win the previous grant takes the tie.
            winner_o = other_owner(owner_e'(last_grant_i));
`else
            winner_o = OWN_LSU;
`endif
        end else if (lsu_valid_i) begin
            winner_o = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and LSU requests onto one memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie resolution (default: LSU-priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ISA_WIDTH,
    parameter int unsigned MASK_W = MEM_MASK_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [ADDR_W-1:0] if_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [ADDR_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_mask,
    input  logic              lsu_wen,
    output logic              lsu_rsp_valid,
    output logic [ADDR_W-1:0] lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    output logic              mem_wen,
    input  logic              mem_rsp_valid,
    input  logic [ADDR_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              wen_q, wen_d;
    owner_e            owner_q, owner_d;

    logic grant;
    logic winner;
    logic accept;
    logic rsp;
    logic in_req;

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
`endif

    mem_arb_sel u_sel (
        .if_valid_i   (if_req_valid),
        .lsu_valid_i  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant_i (last_q),
`endif
        .grant_o      (grant),
        .winner_o     (winner)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        wen_d   = wen_q;
        owner_d = owner_q;
        accept  = 1'b0;
        rsp     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    accept  = 1'b1;
                    owner_d = owner_e'(winner);
                    state_d = StReq;
                    if (owner_e'(winner) == OWN_LSU) begin
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        mask_d  = lsu_mask;
                        wen_d   = lsu_wen;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        mask_d  = '1;
                        wen_d   = 1'b0;
                    end
                end
            end
            StReq: begin
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                // Responses arriving in any other state are stray and dropped.
                if (mem_rsp_valid) begin
                    rsp     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (accept) last_d = owner_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            wen_q   <= 1'b0;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            wen_q   <= wen_d;
            owner_q <= owner_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Reset as if fetch won last, so the first tie goes to the LSU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= OWN_IF;
        else        last_q <= last_d;
    end
`endif

    assign in_req = (state_q == StReq);

    // Ready is gated by reset so every output reads zero while rst_n is low.
    assign if_req_ready  = rst_n & accept & (owner_d == OWN_IF);
    assign lsu_req_ready = rst_n & accept & (owner_d == OWN_LSU);

    assign mem_req_valid = in_req;
    assign mem_addr      = in_req ? addr_q  : '0;
    assign mem_wdata     = in_req ? wdata_q : '0;
    assign mem_mask      = in_req ? mask_q  : '0;
    assign mem_wen       = in_req & wen_q;

    assign if_rsp_valid  = rsp & (owner_q == OWN_IF);
    assign lsu_rsp_valid = rsp & (owner_q == OWN_LSU);
    assign if_rdata      = (if_rsp_valid && !wen_q)  ? mem_rdata : '0;
    assign lsu_rdata     = (lsu_rsp_valid && !wen_q) ? mem_rdata : '0;

endmodule
